// File: rtl/soc_boot_pkg.sv
// rtl/soc_boot_pkg.sv - shared types and constants for the UART boot loader (BOOT_CHECKSUM_EN adds CSUM)
package soc_boot_pkg;

    localparam int         LEN_W             = 16;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
`ifdef BOOT_CHECKSUM_EN
        CSUM   = 3'd4,
`endif
        ERR    = 3'd5
    } boot_state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// rtl/boot_word_assembler.sv - packs four bytes little-endian into a 32-bit word
module boot_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word_out,
    output logic        word_done
);

    logic [1:0]  byte_idx;
    logic [23:0] shreg;

    // Hold the three low bytes; the fourth completes the word on the same cycle it arrives.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_idx <= '0;
            shreg    <= '0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    shreg[7:0]   <= byte_in;
                2'd1:    shreg[15:8]  <= byte_in;
                2'd2:    shreg[23:16] <= byte_in;
                default: shreg        <= shreg;
            endcase
        end
    end

    assign word_done = byte_valid && !clr && (byte_idx == 2'd3);
    assign word_out  = {byte_in, shreg};

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART image loader writing 32-bit words to program RAM (option: BOOT_CHECKSUM_EN)
module uart_boot_loader
    import soc_boot_pkg::*;
#(
    parameter int         ADDR_W         = 15,
    parameter int         BASE_ADDR      = 0,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam longint           MAX_WORDS = longint'(1) << ADDR_W;

    boot_state_t       state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              hold_d, err_d, done_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [LEN_W-1:0]  len_new;
    logic              last_word, timeout_hit;
    logic [31:0]       asm_word;
    logic              asm_done, asm_clr, asm_valid;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              csum_ok;
`endif

    assign asm_valid   = rx_valid && (state_q == DATA);
    assign asm_clr     = (state_q != DATA);
    assign len_new     = {rx_data, len_q[7:0]};
    assign last_word   = (word_idx_q == len_q - LEN_W'(1));
    assign timeout_hit = !rx_valid && (tmo_cnt == TMO_LAST);
    assign busy        = (state_q != IDLE);
`ifdef BOOT_CHECKSUM_EN
    assign csum_ok     = (8'(sum_q + rx_data) == 8'h00);
`endif

    boot_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .byte_in   (rx_data),
        .byte_valid(asm_valid),
        .word_out  (asm_word),
        .word_done (asm_done)
    );

    // Frame sequencing: next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        hold_d     = cpu_hold;
        err_d      = load_err;
        done_d     = 1'b0;
        we_d       = 1'b0;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
`ifdef BOOT_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = LEN_LO;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end else if (timeout_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d      = len_new;
                    word_idx_d = '0;
`ifdef BOOT_CHECKSUM_EN
                    sum_d      = 8'h00;
`endif
                    if ((len_new == '0) || (longint'(len_new) > MAX_WORDS)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end else if (timeout_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            DATA: begin
                if (rx_valid) begin
`ifdef BOOT_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (asm_done) begin
                        we_d       = 1'b1;
                        addr_d     = ADDR_W'(BASE_ADDR + int'(word_idx_q));
                        wdata_d    = asm_word;
                        word_idx_d = word_idx_q + LEN_W'(1);
                        if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d = CSUM;
`else
                            state_d = IDLE;
                            done_d  = 1'b1;
                            hold_d  = 1'b0;
`endif
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CSUM: begin
                if (rx_valid) begin
                    if (csum_ok) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
`endif
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered RAM/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_we     <= we_d;
            cpu_hold   <= hold_d;
            load_done  <= done_d;
            load_err   <= err_d;
        end
    end

    // Inter-byte silence counter; only meaningful while a frame is open.
    always_ff @(posedge clk) begin
        if (rst || rx_valid || (state_q == IDLE) || (state_q == ERR)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running 8-bit payload sum checked against the trailing byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader (honours BOOT_CHECKSUM_EN)
module tb_uart_boot_loader;

    localparam int         ADDR_W    = 15;
    localparam int         BASE_ADDR = 0;
    localparam int         TMO       = 100;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              busy;
    logic              load_done;
    logic              load_err;

    always #5 clk = ~clk;

    uart_boot_loader #(
        .ADDR_W        (ADDR_W),
        .BASE_ADDR     (BASE_ADDR),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .load_done(load_done),
        .load_err (load_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    typedef struct {
        int len;
        int sent;
        int delta;
        int max_gap;
        bit exp_ok;
        int exp_w;
    } vec_t;

    wr_t        wlog[$];
    logic [7:0] pl[$];
    int         byte_cyc[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         err_rise_cnt = 0;
    int         err_rise_cyc = 0;
    logic       err_prev = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         last_sc = 0;
    vec_t       vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) wlog.push_back('{mem_addr, mem_wdata, cyc});
        if (load_done) done_cnt <= done_cnt + 1;
        if (load_err && !err_prev) begin
            err_rise_cnt <= err_rise_cnt + 1;
            err_rise_cyc <= cyc;
        end
        err_prev <= load_err;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        last_sc  = cyc + 1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            rx_valid = 1'b0;
            k++;
        end while (busy && k < bound);
        chk({tag, "_idle"}, busy, 0);
        gap(2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_err"}, load_err, 0);
    endtask

    function automatic void fill_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endfunction

    // Send one frame from pl[] and compare against the frame-level model.
    task automatic run_frame(input string tag, input int len, input int sent, input int delta,
                             input int max_gap, input bit exp_ok, input int exp_w);
        int         base_done;
        int         base_err;
        int         nw;
        bit         len_ok;
        logic [7:0] sum;
        logic [7:0] lb;
        logic [7:0] hb;
        logic [15:0] l16;
        wlog.delete();
        byte_cyc.delete();
        base_done = done_cnt;
        base_err  = err_rise_cnt;
        l16 = 16'(len);
        lb  = l16[7:0];
        hb  = l16[15:8];
        send_byte(SYNC);
        send_byte(lb);
        chk({tag, "_hold_on"}, cpu_hold, 1);
        chk({tag, "_err_clr"}, load_err, 0);
        send_byte(hb);
        sum = 8'h00;
        for (int i = 0; i < sent; i++) begin
            if (max_gap > 0) gap($urandom_range(0, max_gap));
            send_byte(pl[i]);
            byte_cyc.push_back(last_sc);
            sum = sum + pl[i];
        end
        len_ok = (len >= 1) && (len <= (1 << ADDR_W));
`ifdef BOOT_CHECKSUM_EN
        if (len_ok && sent == 4 * len) send_byte(8'(8'h00 - sum + 8'(delta)));
`endif
        if (len_ok && sent < 4 * len) begin
            wait_idle(tag, TMO + 50);
            chk({tag, "_tmo_cyc"}, err_rise_cyc, last_sc + TMO);
        end else begin
            wait_idle(tag, TMO + 50);
        end
        nw = len_ok ? sent / 4 : 0;
        if (nw > len) nw = len;
        chk({tag, "_nwr"}, wlog.size(), exp_w);
        for (int k = 0; k < nw && k < wlog.size(); k++) begin
            chk({tag, "_addr"}, wlog[k].addr, ADDR_W'((BASE_ADDR + k) % (1 << ADDR_W)));
            chk({tag, "_data"}, wlog[k].data, {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]});
            chk({tag, "_lat"}, wlog[k].cyc, byte_cyc[4*k+3]);
        end
        chk({tag, "_done"}, done_cnt - base_done, exp_ok ? 1 : 0);
        chk({tag, "_errp"}, err_rise_cnt - base_err, exp_ok ? 0 : 1);
        chk({tag, "_hold"}, cpu_hold, exp_ok ? 0 : 1);
        chk({tag, "_err"}, load_err, exp_ok ? 0 : 1);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        vecs[0] = '{0,       0,  0, 0, 1'b0, 0};
        vecs[1] = '{32'h8001, 0, 0, 0, 1'b0, 0};
        vecs[2] = '{1,       4,  0, 0, 1'b1, 1};
        vecs[3] = '{3,       12, 0, 2, 1'b1, 3};
        vecs[4] = '{2,       6,  0, 0, 1'b0, 1};
`ifdef BOOT_CHECKSUM_EN
        vecs[5] = '{2,       8,  1, 0, 1'b0, 2};
`else
        vecs[5] = '{2,       8,  1, 0, 1'b1, 2};
`endif
        vecs[6] = '{5,       20, 0, 1, 1'b1, 5};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        pl.delete();
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33); pl.push_back(8'h44);
        pl.push_back(8'h55); pl.push_back(8'h66); pl.push_back(8'h77); pl.push_back(8'h88);
        run_frame("t1", 2, 8, 0, 0, 1'b1, 2);
        chk("t1_word0", wlog.size() > 0 ? wlog[0].data : 32'h0, 32'h44332211);
        chk("t1_word1", wlog.size() > 1 ? wlog[1].data : 32'h0, 32'h88776655);

        wlog.delete();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        gap(3);
        chk("idle_busy", busy, 0);
        chk("idle_hold", cpu_hold, 0);
        chk("idle_nwr", wlog.size(), 0);
        fill_payload(4);
        run_frame("t2", 1, 4, 0, 0, 1'b1, 1);

        for (int v = 0; v < 7; v++) begin
            fill_payload(vecs[v].sent);
            run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].sent, vecs[v].delta,
                      vecs[v].max_gap, vecs[v].exp_ok, vecs[v].exp_w);
        end

        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 6);
            fill_payload(4 * len);
            run_frame($sformatf("rnd%0d", r), len, 4 * len, 0, $urandom_range(0, 2), 1'b1, len);
        end

        wlog.delete();
        pl.delete();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            pl.push_back(b);
        end
        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h00);
        for (int i = 0; i < 9; i++) send_byte(pl[i]);
        @(negedge clk);
        rx_data  = pl[9];
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        chk_reset_outputs("midrst");
        chk("midrst_nwr", wlog.size(), 2);
        for (int i = 10; i < 16; i++) send_byte(pl[i]);
        gap(3);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_hold", cpu_hold, 0);
        chk("post_rst_nwr", wlog.size(), 2);
        fill_payload(8);
        run_frame("t6", 2, 8, 0, 0, 1'b1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
